// File: rtl/brew_arbiter.sv
// brew_arbiter: round-robin arbiter sharing one brewing unit
// among several front-ends; sequences grind, brew and optional milk.
module brew_arbiter #(
  parameter int N_REQ     = 4,
  parameter int GRIND_CYC = 4,
  parameter int BREW_CYC  = 8,
  parameter int MILK_CYC  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_power_on,
  input  logic             i_milk_present,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_milk_req,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_grinder_en,
  output logic             o_pump_en,
  output logic             o_milk_en,
  output logic [N_REQ-1:0] o_done,
  output logic             o_milk_fault,
  output logic             o_abort,
  output logic             o_busy,
  output logic [7:0]       o_cups
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int MAX_GB = (GRIND_CYC > BREW_CYC) ? GRIND_CYC : BREW_CYC;
  localparam int MAXC   = (MAX_GB > MILK_CYC) ? MAX_GB : MILK_CYC;
  localparam int CNT_W  = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRIND,
    S_BREW,
    S_MILK,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic               r_want_milk;
  logic [N_REQ-1:0]   r_grant;
  logic               r_grind;
  logic               r_pump;
  logic               r_milk;
  logic [N_REQ-1:0]   r_done;
  logic               r_fault;
  logic               r_abort;
  logic               r_busy;
  logic [7:0]         r_cups;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [N_REQ-1:0]   w_onehot;
  logic [PTR_W-1:0]   w_ptr_nxt;

  function automatic logic [PTR_W-1:0] rot(
    input logic [PTR_W-1:0] p,
    input int               i
  );
    int s;
    s = int'(p) + i;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // cyclic search for the first request at or after the pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[rot(r_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = rot(r_ptr, i);
      end
    end
  end

  assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_nxt = (r_win == PTR_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

  // service sequencer with registered actuator and status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
      r_want_milk <= 1'b0;
      r_grant     <= '0;
      r_grind     <= 1'b0;
      r_pump      <= 1'b0;
      r_milk      <= 1'b0;
      r_done      <= '0;
      r_fault     <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_cups      <= '0;
    end else begin
      r_done  <= '0;
      r_fault <= 1'b0;
      r_abort <= 1'b0;
      if (r_state != S_IDLE && !i_power_on) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_grant <= '0;
        r_grind <= 1'b0;
        r_pump  <= 1'b0;
        r_milk  <= 1'b0;
        r_busy  <= 1'b0;
        r_abort <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_power_on && w_found) begin
              r_state     <= S_GRIND;
              r_win       <= w_win;
              r_grant     <= w_onehot;
              r_want_milk <= i_milk_req[w_win];
              r_grind     <= 1'b1;
              r_busy      <= 1'b1;
              r_cnt       <= '0;
            end
          end
          S_GRIND: begin
            if (r_cnt == CNT_W'(GRIND_CYC - 1)) begin
              r_state <= S_BREW;
              r_grind <= 1'b0;
              r_pump  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_BREW: begin
            if (r_cnt == CNT_W'(BREW_CYC - 1)) begin
              r_pump <= 1'b0;
              r_cnt  <= '0;
              if (r_want_milk && i_milk_present) begin
                r_state <= S_MILK;
                r_milk  <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= r_grant;
                r_cups  <= r_cups + 8'd1;
                r_fault <= r_want_milk;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_MILK: begin
            if (!i_milk_present ||
                r_cnt == CNT_W'(MILK_CYC - 1)) begin
              r_state <= S_DONE;
              r_milk  <= 1'b0;
              r_cnt   <= '0;
              r_done  <= r_grant;
              r_cups  <= r_cups + 8'd1;
              r_fault <= !i_milk_present;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_nxt;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_grant      = r_grant;
  assign o_grinder_en = r_grind;
  assign o_pump_en    = r_pump;
  assign o_milk_en    = r_milk;
  assign o_done       = r_done;
  assign o_milk_fault = r_fault;
  assign o_abort      = r_abort;
  assign o_busy       = r_busy;
  assign o_cups       = r_cups;

endmodule

// File: tb/tb_brew_arbiter.sv
// tb_brew_arbiter: directed scenarios for brew_arbiter with
// hand-computed expectations for the default parameters.
module tb_brew_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       power_on;
  logic       milk_present;
  logic [3:0] req;
  logic [3:0] milk_req;
  logic [3:0] grant;
  logic       grinder;
  logic       pump;
  logic       milk_en;
  logic [3:0] done;
  logic       fault;
  logic       abort;
  logic       busy;
  logic [7:0] cups;

  brew_arbiter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_power_on     (power_on),
    .i_milk_present (milk_present),
    .i_req          (req),
    .i_milk_req     (milk_req),
    .o_grant        (grant),
    .o_grinder_en   (grinder),
    .o_pump_en      (pump),
    .o_milk_en      (milk_en),
    .o_done         (done),
    .o_milk_fault   (fault),
    .o_abort        (abort),
    .o_busy         (busy),
    .o_cups         (cups)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int g_cnt [4];
  int d_cnt [4];
  int grind_c, pump_c, milk_c, fault_c, abort_c;
  int overlap_c, gap_c;
  int order [$];
  logic [3:0] prev_grant;
  bit drop_on_done;

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      g_cnt[i] = 0;
      d_cnt[i] = 0;
    end
    grind_c = 0; pump_c = 0; milk_c = 0;
    fault_c = 0; abort_c = 0;
    overlap_c = 0; gap_c = 0;
    order.delete();
    prev_grant = grant;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) g_cnt[i]++;
      if (done[i]) begin
        d_cnt[i]++;
        if (drop_on_done) begin
          req[i]      = 1'b0;
          milk_req[i] = 1'b0;
        end
      end
    end
    if (grinder) grind_c++;
    if (pump)    pump_c++;
    if (milk_en) milk_c++;
    if (fault)   fault_c++;
    if (abort)   abort_c++;
    if (int'(grinder) + int'(pump) + int'(milk_en) > 1) overlap_c++;
    if (prev_grant != 0 && grant != 0 && grant != prev_grant) gap_c++;
    if (prev_grant == 0 && grant != 0)
      for (int i = 0; i < 4; i++) if (grant[i]) order.push_back(i);
    prev_grant = grant;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; power_on = 1'b1; milk_present = 1'b1;
    req = '0; milk_req = '0; drop_on_done = 1'b1;
    #12;
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
    total++; if ({grinder, pump, milk_en} !== 3'b0) begin bad++; $display("FAIL rst_en got=%b want=000", {grinder, pump, milk_en}); end
    total++; if ({done, fault, abort, busy} !== 7'b0) begin bad++; $display("FAIL rst_pulse got=%b want=0", {done, fault, abort, busy}); end
    total++; if (cups !== 8'd0) begin bad++; $display("FAIL rst_cups got=%0d want=0", cups); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    clr();
    drop_on_done = 1'b1;
    req = 4'b0001; milk_req = 4'b0000;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL lat_grant got=%b want=0001", grant); end
    total++; if (grinder !== 1'b1) begin bad++; $display("FAIL lat_grind got=%b want=1", grinder); end
    repeat (16) step();
    total++; if (g_cnt[0] != 13) begin bad++; $display("FAIL single_grant got=%0d want=13", g_cnt[0]); end
    total++; if (grind_c != 4) begin bad++; $display("FAIL single_grind got=%0d want=4", grind_c); end
    total++; if (pump_c != 8) begin bad++; $display("FAIL single_pump got=%0d want=8", pump_c); end
    total++; if (milk_c != 0) begin bad++; $display("FAIL single_milk got=%0d want=0", milk_c); end
    total++; if (d_cnt[0] != 1) begin bad++; $display("FAIL single_done got=%0d want=1", d_cnt[0]); end
    total++; if (cups !== 8'd1) begin bad++; $display("FAIL single_cups got=%0d want=1", cups); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
  endtask

  task automatic test_milk();
    clr();
    drop_on_done = 1'b1;
    req = 4'b0010; milk_req = 4'b0010; milk_present = 1'b1;
    repeat (20) step();
    total++; if (g_cnt[1] != 16) begin bad++; $display("FAIL milk_grant got=%0d want=16", g_cnt[1]); end
    total++; if (pump_c != 8) begin bad++; $display("FAIL milk_pump got=%0d want=8", pump_c); end
    total++; if (milk_c != 3) begin bad++; $display("FAIL milk_en got=%0d want=3", milk_c); end
    total++; if (d_cnt[1] != 1) begin bad++; $display("FAIL milk_done got=%0d want=1", d_cnt[1]); end
    total++; if (fault_c != 0) begin bad++; $display("FAIL milk_fault got=%0d want=0", fault_c); end
    total++; if (overlap_c != 0) begin bad++; $display("FAIL milk_overlap got=%0d want=0", overlap_c); end
    total++; if (cups !== 8'd2) begin bad++; $display("FAIL milk_cups got=%0d want=2", cups); end
  endtask

  task automatic test_no_milk();
    clr();
    drop_on_done = 1'b1;
    req = 4'b0001; milk_req = 4'b0001; milk_present = 1'b0;
    repeat (17) step();
    total++; if (g_cnt[0] != 13) begin bad++; $display("FAIL nomilk_grant got=%0d want=13", g_cnt[0]); end
    total++; if (milk_c != 0) begin bad++; $display("FAIL nomilk_en got=%0d want=0", milk_c); end
    total++; if (fault_c != 1) begin bad++; $display("FAIL nomilk_fault got=%0d want=1", fault_c); end
    total++; if (d_cnt[0] != 1) begin bad++; $display("FAIL nomilk_done got=%0d want=1", d_cnt[0]); end
    total++; if (cups !== 8'd3) begin bad++; $display("FAIL nomilk_cups got=%0d want=3", cups); end
    milk_present = 1'b1;
  endtask

  task automatic test_round_robin();
    int budget;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    clr();
    drop_on_done = 1'b0;
    req = 4'b1011; milk_req = 4'b0000;
    budget = 0;
    while (order.size() < 4 && budget < 80) begin
      step();
      budget++;
    end
    total++; if (order.size() < 4) begin bad++; $display("FAIL rr_timeout got=%0d grants want=4", order.size()); end
    if (order.size() >= 4) begin
      total++; if (order[0] != 0) begin bad++; $display("FAIL rr_order0 got=%0d want=0", order[0]); end
      total++; if (order[1] != 1) begin bad++; $display("FAIL rr_order1 got=%0d want=1", order[1]); end
      total++; if (order[2] != 3) begin bad++; $display("FAIL rr_order2 got=%0d want=3", order[2]); end
      total++; if (order[3] != 0) begin bad++; $display("FAIL rr_order3 got=%0d want=0", order[3]); end
    end
    total++; if (d_cnt[0] + d_cnt[1] + d_cnt[3] != 3) begin bad++; $display("FAIL rr_done got=%0d want=3", d_cnt[0] + d_cnt[1] + d_cnt[3]); end
    total++; if (cups !== 8'd3) begin bad++; $display("FAIL rr_cups got=%0d want=3", cups); end
    req = 4'b0000;
    budget = 0;
    while (busy && budget < 30) begin
      step();
      budget++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b want=0", busy); end
    total++; if (gap_c != 0) begin bad++; $display("FAIL rr_gap got=%0d want=0", gap_c); end
    total++; if (overlap_c != 0) begin bad++; $display("FAIL rr_overlap got=%0d want=0", overlap_c); end
    total++; if (cups !== 8'd4) begin bad++; $display("FAIL rr_cups_end got=%0d want=4", cups); end
  endtask

  task automatic test_power_loss();
    clr();
    drop_on_done = 1'b0;
    req = 4'b0101; milk_req = 4'b0000;
    step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL pwr_first got=%b want=0100", grant); end
    repeat (6) step();
    total++; if (pump !== 1'b1) begin bad++; $display("FAIL pwr_inbrew got=%b want=1", pump); end
    power_on = 1'b0;
    step();
    total++; if ({grinder, pump, milk_en} !== 3'b0) begin bad++; $display("FAIL pwr_en got=%b want=000", {grinder, pump, milk_en}); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL pwr_grant got=%b want=0000", grant); end
    total++; if (abort !== 1'b1) begin bad++; $display("FAIL pwr_abort got=%b want=1", abort); end
    total++; if ({done, busy} !== 5'b0) begin bad++; $display("FAIL pwr_done got=%b want=0", {done, busy}); end
    total++; if (cups !== 8'd4) begin bad++; $display("FAIL pwr_cups got=%0d want=4", cups); end
    power_on = 1'b1;
    step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL pwr_regrant got=%b want=0100", grant); end
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL pwr_abort_pulse got=%b want=0", abort); end
    req = 4'b0100;
    drop_on_done = 1'b1;
    repeat (14) step();
    total++; if (d_cnt[2] != 1) begin bad++; $display("FAIL pwr_done_after got=%0d want=1", d_cnt[2]); end
    total++; if (cups !== 8'd5) begin bad++; $display("FAIL pwr_cups_after got=%0d want=5", cups); end
  endtask

  task automatic test_async_reset();
    clr();
    drop_on_done = 1'b0;
    req = 4'b0001; milk_req = 4'b0001; milk_present = 1'b1;
    repeat (13) step();
    total++; if (milk_en !== 1'b1) begin bad++; $display("FAIL ar_inmilk got=%b want=1", milk_en); end
    total++; if (cups !== 8'd5) begin bad++; $display("FAIL ar_cups_pre got=%0d want=5", cups); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if ({grant, grinder, pump, milk_en} !== 7'b0) begin bad++; $display("FAIL ar_outs got=%b want=0", {grant, grinder, pump, milk_en}); end
    total++; if ({done, fault, abort, busy} !== 7'b0) begin bad++; $display("FAIL ar_pulses got=%b want=0", {done, fault, abort, busy}); end
    total++; if (cups !== 8'd0) begin bad++; $display("FAIL ar_cups got=%0d want=0", cups); end
    req = 4'b1010; milk_req = 4'b0000;
    #2;
    rst_n = 1'b1;
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL ar_regrant got=%b want=0010", grant); end
    total++; if (grinder !== 1'b1) begin bad++; $display("FAIL ar_grind got=%b want=1", grinder); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_milk();
    test_no_milk();
    test_round_robin();
    test_power_loss();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
